// File: rtl/sfp_link_supervisor.sv
// Per-channel SFP+ link bring-up / fault-recovery sequencer.
// Each channel conditions LOS/TX_FAULT/MOD_ABS and sequences the PHY reset and TX_DISABLE.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ABSENT     | no module present; PHY held in reset, laser disabled
// RESET      | PHY reset held for P_RESET_CYCLES
// WAIT_READY | PHY released, waiting for ready (timeout only while light is present)
// UP         | link up
// FAULT      | TX_DISABLE pulse to clear a transmitter fault
// LOCKOUT    | retries exhausted; waits for i_restart
module sfp_link_supervisor #(
    parameter int P_CHANNELS        = 1,
    parameter int P_DEBOUNCE_CYCLES = 1024,
    parameter int P_RESET_CYCLES    = 256,
    parameter int P_READY_TIMEOUT   = 2**20,
    parameter int P_TXDIS_CYCLES    = 1024,
    parameter int P_MAX_RETRIES     = 7
) (
    input  logic                                                 i_clock,
    input  logic                                                 i_reset_n,
    input  logic [P_CHANNELS-1:0]                                i_sfp_los,
    input  logic [P_CHANNELS-1:0]                                i_sfp_tx_fault,
    input  logic [P_CHANNELS-1:0]                                i_sfp_mod_abs,
    input  logic [P_CHANNELS-1:0]                                i_phy_ready,
    input  logic [P_CHANNELS-1:0]                                i_restart,
    output logic [P_CHANNELS-1:0]                                o_phy_reset_n,
    output logic [P_CHANNELS-1:0]                                o_sfp_tx_disable,
    output logic [P_CHANNELS-1:0]                                o_link_up,
    output logic [P_CHANNELS-1:0]                                o_lockout,
    output logic [P_CHANNELS-1:0]                                o_link_change,
    output logic [P_CHANNELS-1:0][2:0]                           o_state,
    output logic [P_CHANNELS-1:0][$clog2(P_MAX_RETRIES+1)-1:0]   o_retry_count
);

    localparam int T_MAX_A = (P_RESET_CYCLES > P_TXDIS_CYCLES) ? P_RESET_CYCLES : P_TXDIS_CYCLES;
    localparam int T_MAX   = (P_READY_TIMEOUT > T_MAX_A) ? P_READY_TIMEOUT : T_MAX_A;
    localparam int TW      = $clog2(T_MAX + 1);
    localparam int RW      = $clog2(P_MAX_RETRIES + 1);
    localparam int DW      = $clog2(P_DEBOUNCE_CYCLES + 1);
    // {abs, fault, los}: safe defaults assume no module and no light
    localparam logic [2:0] DB_RST = 3'b101;

    typedef enum logic [2:0] {
        S_ABSENT     = 3'd0,
        S_RESET      = 3'd1,
        S_WAIT_READY = 3'd2,
        S_UP         = 3'd3,
        S_FAULT      = 3'd4,
        S_LOCKOUT    = 3'd5
    } state_e;

    for (genvar c = 0; c < P_CHANNELS; c++) begin : g_ch
        logic [2:0]    raw;
        logic [2:0]    sync1_q, sync2_q, samp_q, db_q, db_d;
        logic [DW-1:0] cnt_q [3];
        logic [DW-1:0] cnt_d [3];
        logic          los_db, fault_db, abs_db;

        assign raw = {i_sfp_mod_abs[c], i_sfp_tx_fault[c], i_sfp_los[c]};

        // two-flop synchroniser followed by a registered debouncer sample
        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                sync1_q <= DB_RST;
                sync2_q <= DB_RST;
                samp_q  <= DB_RST;
                db_q    <= DB_RST;
                for (int j = 0; j < 3; j++) cnt_q[j] <= '0;
            end else begin
                sync1_q <= raw;
                sync2_q <= sync1_q;
                samp_q  <= sync2_q;
                db_q    <= db_d;
                for (int j = 0; j < 3; j++) cnt_q[j] <= cnt_d[j];
            end
        end

        always_comb begin
            db_d = db_q;
            for (int j = 0; j < 3; j++) begin
                cnt_d[j] = '0;
                if (samp_q[j] != db_q[j]) begin
                    if (cnt_q[j] == DW'(P_DEBOUNCE_CYCLES - 1)) db_d[j] = samp_q[j];
                    else                                         cnt_d[j] = cnt_q[j] + 1'b1;
                end
            end
        end

        assign los_db   = db_q[0];
        assign fault_db = db_q[1];
        assign abs_db   = db_q[2];

        state_e        state_q, state_d;
        logic [TW-1:0] timer_q, timer_d;
        logic [RW-1:0] retry_q, retry_d, retry_inc;
        logic          attempt_failed;
        logic          phy_rst_n_q, txdis_q, up_q, up_dly_q, lock_q, chg_q;

        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                state_q     <= S_ABSENT;
                timer_q     <= '0;
                retry_q     <= '0;
                phy_rst_n_q <= 1'b0;
                txdis_q     <= 1'b1;
                up_q        <= 1'b0;
                up_dly_q    <= 1'b0;
                lock_q      <= 1'b0;
                chg_q       <= 1'b0;
            end else begin
                state_q     <= state_d;
                timer_q     <= timer_d;
                retry_q     <= retry_d;
                phy_rst_n_q <= (state_d == S_WAIT_READY) || (state_d == S_UP);
                txdis_q     <= (state_d == S_ABSENT) || (state_d == S_FAULT) || (state_d == S_LOCKOUT);
                up_q        <= (state_d == S_UP);
                up_dly_q    <= up_q;
                lock_q      <= (state_d == S_LOCKOUT);
                chg_q       <= up_q ^ up_dly_q;
            end
        end

        always_comb begin
            state_d        = state_q;
            timer_d        = timer_q + 1'b1;
            retry_d        = retry_q;
            retry_inc      = retry_q + 1'b1;
            attempt_failed = 1'b0;
            if (abs_db) begin
                state_d = S_ABSENT;
                retry_d = '0;
            end else if (fault_db && (state_q inside {S_ABSENT, S_RESET, S_WAIT_READY, S_UP})) begin
                state_d = S_FAULT;
            end else begin
                case (state_q)
                    S_ABSENT:     state_d = S_RESET;
                    S_RESET:      if (timer_q == TW'(P_RESET_CYCLES - 1)) state_d = S_WAIT_READY;
                    S_WAIT_READY: begin
                        if (i_phy_ready[c] && !los_db) begin
                            state_d = S_UP;
                            retry_d = '0;
                        end else if (!los_db && timer_q == TW'(P_READY_TIMEOUT - 1)) begin
                            attempt_failed = 1'b1;
                        end
                    end
                    S_UP:         if (los_db || !i_phy_ready[c]) state_d = S_RESET;
                    S_FAULT:      if (timer_q == TW'(P_TXDIS_CYCLES - 1)) attempt_failed = 1'b1;
                    S_LOCKOUT: begin
                        if (i_restart[c]) begin
                            state_d = S_RESET;
                            retry_d = '0;
                        end
                    end
                    default:      state_d = S_ABSENT;
                endcase
            end
            if (attempt_failed) begin
                retry_d = retry_inc;
                state_d = (retry_inc == RW'(P_MAX_RETRIES)) ? S_LOCKOUT : S_RESET;
            end
            // no light in WAIT_READY is not a failed attempt, so its timer stays parked
            if (state_d != state_q || (state_q inside {S_ABSENT, S_UP, S_LOCKOUT}) ||
                (state_q == S_WAIT_READY && los_db))
                timer_d = '0;
        end

        assign o_phy_reset_n[c]    = phy_rst_n_q;
        assign o_sfp_tx_disable[c] = txdis_q;
        assign o_link_up[c]        = up_q;
        assign o_lockout[c]        = lock_q;
        assign o_link_change[c]    = chg_q;
        assign o_state[c]          = state_q;
        assign o_retry_count[c]    = retry_q;
    end

endmodule

// File: tb/tb_sfp_link_supervisor.sv
// Directed table-driven bench for sfp_link_supervisor (2 channels, short timers).
// Channel 1 is kept absent throughout and must stay quiet while channel 0 is exercised.
module tb_sfp_link_supervisor;

    logic            clk;
    logic            rst_n;
    logic [1:0]      los, flt, abs_i, rdy, rs;
    logic [1:0]      phy_rstn, txd, up, lk, chg;
    logic [1:0][2:0] st;
    logic [1:0][1:0] rt;

    int n_checks = 0;
    int n_errors = 0;

    sfp_link_supervisor #(
        .P_CHANNELS       (2),
        .P_DEBOUNCE_CYCLES(4),
        .P_RESET_CYCLES   (8),
        .P_READY_TIMEOUT  (64),
        .P_TXDIS_CYCLES   (16),
        .P_MAX_RETRIES    (3)
    ) dut (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .i_sfp_los       (los),
        .i_sfp_tx_fault  (flt),
        .i_sfp_mod_abs   (abs_i),
        .i_phy_ready     (rdy),
        .i_restart       (rs),
        .o_phy_reset_n   (phy_rstn),
        .o_sfp_tx_disable(txd),
        .o_link_up       (up),
        .o_lockout       (lk),
        .o_link_change   (chg),
        .o_state         (st),
        .o_retry_count   (rt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         n;
        logic       abs0, los0, flt0, rdy0;
        logic [1:0] rs;
        logic [2:0] st0;
        logic       rstn0, txd0, up0, lk0, chg0;
        logic [1:0] rt0;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(int n, logic a, logic l, logic f, logic r, logic [1:0] rsv,
                                 logic [2:0] s, logic pr, logic td, logic u, logic k,
                                 logic ch, logic [1:0] rc);
        vec_t v;
        v.n = n; v.abs0 = a; v.los0 = l; v.flt0 = f; v.rdy0 = r; v.rs = rsv;
        v.st0 = s; v.rstn0 = pr; v.txd0 = td; v.up0 = u; v.lk0 = k; v.chg0 = ch; v.rt0 = rc;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // bundle order {phy_reset_n, tx_disable, link_up, lockout, link_change}
    task automatic chk_ch1(string tag);
        chk({tag, " ch1 state"}, 32'(st[1]), 32'd0);
        chk({tag, " ch1 outs"}, 32'({phy_rstn[1], txd[1], up[1], lk[1], chg[1]}), 32'b01000);
        chk({tag, " ch1 retry"}, 32'(rt[1]), 32'd0);
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, " ch0 state"}, 32'(st[0]), 32'd0);
        chk({tag, " ch0 outs"}, 32'({phy_rstn[0], txd[0], up[0], lk[0], chg[0]}), 32'b01000);
        chk({tag, " ch0 retry"}, 32'(rt[0]), 32'd0);
        chk_ch1(tag);
    endtask

    initial begin
        // columns: n, abs0, los0, flt0, rdy0, restart | state0, rstn0, txd0, up0, lk0, chg0, retry0
        tbl.push_back(row(  7, 0,0,0,0, 2'b00, 3'd0, 0,1,0,0,0, 2'd0)); // edge 6: debounce not done
        tbl.push_back(row(  1, 0,0,0,0, 2'b00, 3'd1, 0,0,0,0,0, 2'd0)); // 7: RESET
        tbl.push_back(row(  7, 0,0,0,0, 2'b00, 3'd1, 0,0,0,0,0, 2'd0)); // 14
        tbl.push_back(row(  1, 0,0,0,0, 2'b00, 3'd2, 1,0,0,0,0, 2'd0)); // 15: WAIT_READY
        tbl.push_back(row(  1, 0,0,0,1, 2'b00, 3'd3, 1,0,1,0,0, 2'd0)); // 16: UP
        tbl.push_back(row(  1, 0,0,0,1, 2'b00, 3'd3, 1,0,1,0,1, 2'd0)); // 17: change pulse
        tbl.push_back(row(  1, 0,0,0,1, 2'b00, 3'd3, 1,0,1,0,0, 2'd0)); // 18
        tbl.push_back(row(  3, 0,1,0,1, 2'b00, 3'd3, 1,0,1,0,0, 2'd0)); // 3-cycle los glitch
        tbl.push_back(row( 10, 0,0,0,1, 2'b00, 3'd3, 1,0,1,0,0, 2'd0)); // 31: still UP
        tbl.push_back(row(  4, 0,1,0,1, 2'b00, 3'd3, 1,0,1,0,0, 2'd0)); // 4-cycle los, k=32
        tbl.push_back(row(  2, 0,0,0,1, 2'b00, 3'd3, 1,0,1,0,0, 2'd0)); // 37
        tbl.push_back(row(  1, 0,0,0,1, 2'b00, 3'd3, 1,0,1,0,0, 2'd0)); // 38 = k+6
        tbl.push_back(row(  1, 0,0,0,1, 2'b00, 3'd1, 0,0,0,0,0, 2'd0)); // 39 = k+7: RESET
        tbl.push_back(row(  1, 0,0,0,1, 2'b00, 3'd1, 0,0,0,0,1, 2'd0)); // 40: change pulse
        tbl.push_back(row(  7, 0,0,0,1, 2'b00, 3'd2, 1,0,0,0,0, 2'd0)); // 47
        tbl.push_back(row(  1, 0,0,0,1, 2'b00, 3'd3, 1,0,1,0,0, 2'd0)); // 48: UP
        tbl.push_back(row(  1, 0,0,0,1, 2'b00, 3'd3, 1,0,1,0,1, 2'd0)); // 49
        tbl.push_back(row(  4, 0,0,1,1, 2'b00, 3'd3, 1,0,1,0,0, 2'd0)); // fault from k=50
        tbl.push_back(row(  3, 0,0,0,1, 2'b00, 3'd3, 1,0,1,0,0, 2'd0)); // 56
        tbl.push_back(row(  1, 0,0,0,1, 2'b00, 3'd4, 0,1,0,0,0, 2'd0)); // 57: FAULT
        tbl.push_back(row(  1, 0,0,0,1, 2'b00, 3'd4, 0,1,0,0,1, 2'd0)); // 58
        tbl.push_back(row( 14, 0,0,0,1, 2'b00, 3'd4, 0,1,0,0,0, 2'd0)); // 72: 16th cycle disabled
        tbl.push_back(row(  1, 0,0,0,1, 2'b00, 3'd1, 0,0,0,0,0, 2'd1)); // 73: RESET retry 1
        tbl.push_back(row(  8, 0,0,0,1, 2'b00, 3'd2, 1,0,0,0,0, 2'd1)); // 81
        tbl.push_back(row(  1, 0,0,0,1, 2'b00, 3'd3, 1,0,1,0,0, 2'd0)); // 82: UP clears retry
        tbl.push_back(row(  1, 0,0,0,0, 2'b00, 3'd1, 0,0,0,0,1, 2'd0)); // 83: ready lost
        tbl.push_back(row(  1, 0,0,0,0, 2'b00, 3'd1, 0,0,0,0,1, 2'd0)); // 84
        tbl.push_back(row(  7, 0,0,0,0, 2'b00, 3'd2, 1,0,0,0,0, 2'd0)); // 91
        tbl.push_back(row( 63, 0,0,0,0, 2'b00, 3'd2, 1,0,0,0,0, 2'd0)); // 154
        tbl.push_back(row(  1, 0,0,0,0, 2'b00, 3'd1, 0,0,0,0,0, 2'd1)); // 155: timeout 1
        tbl.push_back(row(  8, 0,0,0,0, 2'b00, 3'd2, 1,0,0,0,0, 2'd1)); // 163
        tbl.push_back(row( 64, 0,0,0,0, 2'b00, 3'd1, 0,0,0,0,0, 2'd2)); // 227: timeout 2
        tbl.push_back(row(  8, 0,0,0,0, 2'b00, 3'd2, 1,0,0,0,0, 2'd2)); // 235
        tbl.push_back(row( 63, 0,0,0,0, 2'b00, 3'd2, 1,0,0,0,0, 2'd2)); // 298
        tbl.push_back(row(  1, 0,0,0,0, 2'b00, 3'd5, 0,1,0,1,0, 2'd3)); // 299: LOCKOUT
        tbl.push_back(row(  5, 0,0,0,0, 2'b00, 3'd5, 0,1,0,1,0, 2'd3)); // 304
        tbl.push_back(row(  1, 0,0,0,0, 2'b11, 3'd1, 0,0,0,0,0, 2'd0)); // 305: restart
        tbl.push_back(row(  8, 0,1,0,0, 2'b00, 3'd2, 1,0,0,0,0, 2'd0)); // 313: no light
        tbl.push_back(row(150, 0,1,0,0, 2'b00, 3'd2, 1,0,0,0,0, 2'd0)); // 463: no timeout
        tbl.push_back(row(  8, 0,1,1,0, 2'b00, 3'd4, 0,1,0,0,0, 2'd0)); // 471: FAULT
        tbl.push_back(row( 16, 0,1,1,0, 2'b00, 3'd1, 0,0,0,0,0, 2'd1)); // 487
        tbl.push_back(row(  1, 0,1,1,0, 2'b00, 3'd4, 0,1,0,0,0, 2'd1)); // 488
        tbl.push_back(row( 16, 0,1,1,0, 2'b00, 3'd1, 0,0,0,0,0, 2'd2)); // 504
        tbl.push_back(row(  1, 0,1,1,0, 2'b00, 3'd4, 0,1,0,0,0, 2'd2)); // 505: FAULT retry 2
        tbl.push_back(row(  7, 1,1,1,0, 2'b00, 3'd4, 0,1,0,0,0, 2'd2)); // 512: removal pending
        tbl.push_back(row(  1, 1,1,1,0, 2'b00, 3'd0, 0,1,0,0,0, 2'd0)); // 513: ABSENT
        tbl.push_back(row(  7, 0,0,0,0, 2'b00, 3'd0, 0,1,0,0,0, 2'd0)); // 520
        tbl.push_back(row(  1, 0,0,0,0, 2'b00, 3'd1, 0,0,0,0,0, 2'd0)); // 521: reinserted
        tbl.push_back(row(  8, 0,0,0,0, 2'b00, 3'd2, 1,0,0,0,0, 2'd0)); // 529: WAIT_READY

        rst_n = 1'b0;
        abs_i = 2'b10; los = 2'b10; flt = 2'b00; rdy = 2'b00; rs = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("por");
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("row%0d", i);
            abs_i = {1'b1, tbl[i].abs0};
            los   = {1'b1, tbl[i].los0};
            flt   = {1'b0, tbl[i].flt0};
            rdy   = {1'b0, tbl[i].rdy0};
            rs    = tbl[i].rs;
            repeat (tbl[i].n) @(posedge clk);
            #1;
            chk({tag, " ch0 state"}, 32'(st[0]), 32'(tbl[i].st0));
            chk({tag, " ch0 outs"}, 32'({phy_rstn[0], txd[0], up[0], lk[0], chg[0]}),
                32'({tbl[i].rstn0, tbl[i].txd0, tbl[i].up0, tbl[i].lk0, tbl[i].chg0}));
            chk({tag, " ch0 retry"}, 32'(rt[0]), 32'(tbl[i].rt0));
            chk_ch1(tag);
        end

        // async reset mid WAIT_READY, observed between clock edges
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");

        // debounce must restart from the safe defaults after reset
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("post_rst edge6 state", 32'(st[0]), 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst edge7 state", 32'(st[0]), 32'd1);
        chk("post_rst edge7 txd", 32'(txd), 32'b10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
